// File: rtl/bcd_seq_adder.sv
// bcd_seq_adder: N-digit packed-BCD adder that resolves one decimal digit per
// clock, least significant digit first. Operands are latched on start; the sum
// is committed together with a one-cycle done pulse and held until the next
// completion.
//
// Optional feature macro: BCD_SEQ_ADDER_SUB_EN
//   Defined  : adds a 'sub' input. When set with start, y is replaced digit by
//              digit with its 9's complement and the carry-in is forced to 1, so
//              the result is x - y (cout=1: no borrow; cout=0: 10's complement).
//   Undefined: add only, no 'sub' port.
module bcd_seq_adder #(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   x,
  input  logic [4*DIGITS-1:0]   y,
  input  logic                  cin,
`ifdef BCD_SEQ_ADDER_SUB_EN
  input  logic                  sub,
`endif
  output logic [4*DIGITS-1:0]   out,
  output logic                  cout,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int W  = 4 * DIGITS;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t          state;
  logic [W-1:0]    xa;        // latched x, shifted right one digit per step
  logic [W-1:0]    ya;        // latched (possibly complemented) y, shifted likewise
  logic [W-1:0]    work;      // partial sum, digits enter at the top
  logic [IW-1:0]   idx;
  logic            c;         // decimal carry between digit steps
  logic            flag;      // some latched operand digit was > 9

  logic            sub_eff;
  logic [4:0]      sum;
  logic [3:0]      digit;
  logic            carry_next;
  logic [W-1:0]    work_next;
  logic            last;

`ifdef BCD_SEQ_ADDER_SUB_EN
  assign sub_eff = sub;
`else
  assign sub_eff = 1'b0;
`endif

  // True when any 4-bit digit of v is not a legal BCD digit.
  function automatic logic has_bad_digit(input logic [W-1:0] v);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (v[4*i +: 4] > 4'd9) bad = 1'b1;
    end
    return bad;
  endfunction

  // Digit-wise 9's complement (9 - d, wrapping in 4 bits for illegal digits).
  function automatic logic [W-1:0] nines(input logic [W-1:0] v);
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'd9 - v[4*i +: 4];
    end
    return r;
  endfunction

  // Single-digit decimal adder on the current least significant digits.
  always_comb begin
    // NOTE: every signal written here gets a value before any branch, so no latch can be inferred.
    sum        = {1'b0, xa[3:0]} + {1'b0, ya[3:0]} + {4'b0, c};
    carry_next = 1'b0;
    digit      = sum[3:0];
    if (sum > 5'd9) begin
      carry_next = 1'b1;
      digit      = 4'(sum + 5'd6);
    end
    work_next = (work >> 4) | (W'(digit) << (W - 4));
    last      = (idx == IW'(DIGITS - 1));
  end

  // Control FSM, operand latching, digit stepping and result commit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      xa    <= '0;
      ya    <= '0;
      work  <= '0;
      idx   <= '0;
      c     <= 1'b0;
      flag  <= 1'b0;
      out   <= '0;
      cout  <= 1'b0;
      err   <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            xa    <= x;
            ya    <= sub_eff ? nines(y) : y;
            c     <= sub_eff ? 1'b1 : cin;
            flag  <= has_bad_digit(x) | has_bad_digit(y);
            work  <= '0;
            idx   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          xa   <= xa >> 4;
          ya   <= ya >> 4;
          c    <= carry_next;
          work <= work_next;
          idx  <= idx + 1'b1;
          if (last) begin
            out   <= work_next;
            cout  <= carry_next;
            err   <= flag;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_seq_adder.sv
// tb_bcd_seq_adder: scoreboard bench for bcd_seq_adder (DIGITS=4). Expected
// results come from a decimal-arithmetic reference model and are queued at
// issue time; a monitor pops and compares whenever done is seen.
module tb_bcd_seq_adder;

  localparam int DIGITS = 4;
  localparam int W      = 4 * DIGITS;

  typedef struct {
    logic [W-1:0] out;
    logic         cout;
    logic         err;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] x;
  logic [W-1:0] y;
  logic         cin;
`ifdef BCD_SEQ_ADDER_SUB_EN
  logic         sub;
`endif
  logic [W-1:0] out;
  logic         cout;
  logic         busy;
  logic         done;
  logic         err;

  int errors = 0;
  int checks = 0;

  exp_t         sb_q[$];
  logic [W-1:0] last_exp_out = '0;
  logic [W-1:0] hold_ref     = '0;

  bcd_seq_adder #(.DIGITS(DIGITS)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .x     (x),
    .y     (y),
    .cin   (cin),
`ifdef BCD_SEQ_ADDER_SUB_EN
    .sub   (sub),
`endif
    .out   (out),
    .cout  (cout),
    .busy  (busy),
    .done  (done),
    .err   (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic longint dec(input logic [W-1:0] v);
    longint r = 0;
    for (int i = DIGITS - 1; i >= 0; i--) r = r * 10 + longint'(v[4*i +: 4]);
    return r;
  endfunction

  function automatic logic [W-1:0] to_bcd(input longint n);
    logic [W-1:0] r = '0;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(n % 10);
      n = n / 10;
    end
    return r;
  endfunction

  function automatic logic bad(input logic [W-1:0] v);
    for (int i = 0; i < DIGITS; i++) if (v[4*i +: 4] > 4'd9) return 1'b1;
    return 1'b0;
  endfunction

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic ci, input logic sb);
    exp_t   e;
    longint lim = 1;
    longint s;
    int     carry;
    int     da, db, t;
    for (int i = 0; i < DIGITS; i++) lim = lim * 10;
    e.err  = bad(a) | bad(b);
    e.out  = '0;
    e.cout = 1'b0;
    if (!e.err && !sb) begin
      s      = dec(a) + dec(b) + longint'(ci);
      e.out  = to_bcd(s % lim);
      e.cout = (s >= lim);
    end else if (!e.err && sb) begin
      s = dec(a) - dec(b);
      if (s >= 0) begin
        e.out  = to_bcd(s);
        e.cout = 1'b1;
      end else begin
        e.out  = to_bcd(lim + s);
        e.cout = 1'b0;
      end
    end else begin
      // Illegal digits: follow the digit-by-digit decimal-correct rule literally.
      carry = sb ? 1 : int'(ci);
      for (int i = 0; i < DIGITS; i++) begin
        da = int'(a[4*i +: 4]);
        db = int'(b[4*i +: 4]);
        if (sb) db = (9 - db) & 15;
        t = da + db + carry;
        if (t > 9) begin
          e.out[4*i +: 4] = 4'(t + 6);
          carry = 1;
        end else begin
          e.out[4*i +: 4] = 4'(t);
          carry = 0;
        end
      end
      e.cout = (carry != 0);
    end
    return e;
  endfunction

  // ---------------- monitor ----------------
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (done === 1'b1) begin
        check("done_has_entry", (sb_q.size() > 0), 1);
        if (sb_q.size() > 0) begin
          e = sb_q.pop_front();
          check("sum_out", out, e.out);
          check("sum_cout", cout, e.cout);
          check("sum_err", err, e.err);
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  // Called away from the rising edge; start is held across exactly one edge.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic ci, input logic sb);
    exp_t e;
    e = model(a, b, ci, sb);
    x     = a;
    y     = b;
    cin   = ci;
`ifdef BCD_SEQ_ADDER_SUB_EN
    sub   = sb;
`endif
    start = 1'b1;
    sb_q.push_back(e);
    hold_ref     = last_exp_out;
    last_exp_out = e.out;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Counts falling edges until done; exp_lat is the expected count.
  task automatic wait_done(input int exp_lat);
    int n     = 0;
    int nbusy = 0;
    bit held  = 1'b1;
    bit got   = 1'b0;
    while (n < 3 * DIGITS + 4) begin
      @(negedge clk);
      n++;
      if (done === 1'b1) begin
        got = 1'b1;
        break;
      end
      if (busy === 1'b1) nbusy++;
      if (out !== hold_ref) held = 1'b0;
    end
    check("done_seen", got, 1);
    check("latency", n, exp_lat);
    check("busy_cycles", nbusy, exp_lat - 1);
    check("out_held_in_run", held, 1);
    if (got) check("busy_low_at_done", busy, 0);
  endtask

  function automatic logic [W-1:0] rand_bcd(input bit allow_bad);
    logic [W-1:0] r = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (allow_bad && $urandom_range(0, 7) == 0) r[4*i +: 4] = 4'($urandom_range(10, 15));
      else                                        r[4*i +: 4] = 4'($urandom_range(0, 9));
    end
    return r;
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    rst   = 1'b1;
    start = 1'b0;
    x     = '0;
    y     = '0;
    cin   = 1'b0;
`ifdef BCD_SEQ_ADDER_SUB_EN
    sub   = 1'b0;
`endif
    #1;
    check("rst_out", out, 0);
    check("rst_cout", cout, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Plain add, latency and busy width.
    issue(16'h1234, 16'h4321, 1'b0, 1'b0);
    wait_done(DIGITS + 1);

    // Full carry ripple, then a back-to-back start in the DONE cycle.
    @(negedge clk);
    issue(16'h9999, 16'h0001, 1'b0, 1'b0);
    wait_done(DIGITS + 1);
    issue(16'h0666, 16'h0666, 1'b1, 1'b0);
    wait_done(DIGITS + 1);

    // Reset mid-operation aborts with nothing committed.
    @(negedge clk);
    issue(16'h5000, 16'h5000, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_out", out, 0);
    check("abort_cout", cout, 0);
    check("abort_err", err, 0);
    sb_q.delete();
    last_exp_out = '0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    issue(16'h0001, 16'h0002, 1'b0, 1'b0);
    wait_done(DIGITS + 1);

    // Start and operand changes while busy are ignored.
    @(negedge clk);
    issue(16'h1111, 16'h2222, 1'b0, 1'b0);
    @(negedge clk);
    x     = 16'h9999;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(DIGITS);

    // Illegal digit flagged, then cleared by the next legal operation.
    @(negedge clk);
    issue(16'h00A0, 16'h0000, 1'b0, 1'b0);
    wait_done(DIGITS + 1);
    @(negedge clk);
    issue(16'h0042, 16'h0058, 1'b0, 1'b0);
    wait_done(DIGITS + 1);

`ifdef BCD_SEQ_ADDER_SUB_EN
    @(negedge clk);
    issue(16'h0100, 16'h0001, 1'b0, 1'b1);
    wait_done(DIGITS + 1);
    @(negedge clk);
    issue(16'h0001, 16'h0002, 1'b1, 1'b1);
    wait_done(DIGITS + 1);
`endif

    // Randomised operations with mixed idle gaps and back-to-back starts.
    for (int i = 0; i < 40; i++) begin
      logic sb_r;
`ifdef BCD_SEQ_ADDER_SUB_EN
      sb_r = 1'($urandom_range(0, 1));
`else
      sb_r = 1'b0;
`endif
      if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) @(negedge clk);
      issue(rand_bcd(1'b1), rand_bcd(1'b1), 1'($urandom_range(0, 1)), sb_r);
      wait_done(DIGITS + 1);
    end

    repeat (3) @(negedge clk);
    check("queue_drained", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
